// File: rtl/psum_accum.sv
// Partial-sum accumulator: folds groups of signed dot-product sums into
// one saturated wide sum, with zero-group tracking and back-pressure.
module psum_accum #(
  parameter int IDWd  = 16,
  parameter int ODWd  = 24,
  parameter int CntWd = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_work,
  input  logic [CntWd-1:0] i_acc_len,
  input  logic [IDWd-1:0]  i_sum,
  input  logic             sum_rdy,
  output logic             sum_ack,
  input  logic             sum_zero,
  output logic [ODWd-1:0]  o_psum,
  output logic             psum_rdy,
  input  logic             psum_ack,
  output logic             psum_zero,
  output logic             o_busy,
  output logic             o_ovf
);

  localparam logic [ODWd-1:0] SatMax =
    {1'b0, {(ODWd-1){1'b1}}};
  localparam logic [ODWd-1:0] SatMin =
    {1'b1, {(ODWd-1){1'b0}}};

  logic [ODWd-1:0]  acc_q, acc_d;
  logic [CntWd-1:0] cnt_q, cnt_d;
  logic             zacc_q, zacc_d;
  logic [CntWd-1:0] len_q, len_d;
  logic [ODWd-1:0]  psum_q, psum_d;
  logic             psum_rdy_q, psum_rdy_d;
  logic             psum_zero_q, psum_zero_d;
  logic             ovf_q, ovf_d;

  logic             beat;
  logic             first;
  logic             last;
  logic [CntWd-1:0] len_in;
  logic [CntWd-1:0] len_eff;
  logic [CntWd:0]   cnt_nx;
  logic [ODWd-1:0]  v;
  logic [ODWd:0]    sum_w;
  logic             clamp;
  logic [ODWd-1:0]  sum_sat;

  assign sum_ack = i_work && (!psum_rdy_q || psum_ack)
                   && !i_rst;
  assign beat    = sum_rdy && sum_ack;

  assign v = sum_zero ? '0 :
    {{(ODWd-IDWd){i_sum[IDWd-1]}}, i_sum};

  // One guard bit catches overflow of the running sum
  assign sum_w = {acc_q[ODWd-1], acc_q} + {v[ODWd-1], v};
  assign clamp = sum_w[ODWd] != sum_w[ODWd-1];

  always_comb begin
    sum_sat = sum_w[ODWd-1:0];
    if (clamp) begin
      sum_sat = sum_w[ODWd] ? SatMin : SatMax;
    end
  end

  assign first   = cnt_q == '0;
  assign len_in  = (i_acc_len == '0) ? {{(CntWd-1){1'b0}}, 1'b1}
                                     : i_acc_len;
  assign len_eff = first ? len_in : len_q;
  assign cnt_nx  = {1'b0, cnt_q} + {{CntWd{1'b0}}, 1'b1};
  assign last    = cnt_nx == {1'b0, len_eff};

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    zacc_d      = zacc_q;
    len_d       = len_q;
    psum_d      = psum_q;
    psum_rdy_d  = psum_rdy_q;
    psum_zero_d = psum_zero_q;
    ovf_d       = ovf_q;
    if (i_work) begin
      if (psum_rdy_q && psum_ack) begin
        psum_rdy_d = 1'b0;
      end
      if (beat) begin
        if (first) begin
          len_d = len_in;
        end
        if (clamp) begin
          ovf_d = 1'b1;
        end
        if (last) begin
          psum_d      = sum_sat;
          psum_zero_d = zacc_q & sum_zero;
          psum_rdy_d  = 1'b1;
          acc_d       = '0;
          zacc_d      = 1'b1;
          cnt_d       = '0;
        end else begin
          acc_d  = sum_sat;
          zacc_d = zacc_q & sum_zero;
          cnt_d  = cnt_nx[CntWd-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      zacc_q      <= 1'b1;
      len_q       <= '0;
      psum_q      <= '0;
      psum_rdy_q  <= 1'b0;
      psum_zero_q <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      zacc_q      <= zacc_d;
      len_q       <= len_d;
      psum_q      <= psum_d;
      psum_rdy_q  <= psum_rdy_d;
      psum_zero_q <= psum_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_psum    = psum_q;
  assign psum_rdy  = psum_rdy_q;
  assign psum_zero = psum_zero_q;
  assign o_busy    = cnt_q != '0;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: default build plus a narrow
// ODWd=17 build sharing the same inputs to exercise saturation.
module tb_psum_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               work;
  logic [7:0]         acc_len;
  logic [15:0]        i_sum;
  logic               sum_rdy;
  logic               sum_zero;
  logic               psum_ack;

  logic               sum_ack;
  logic signed [23:0] o_psum;
  logic               psum_rdy;
  logic               psum_zero;
  logic               busy;
  logic               ovf;

  logic               sum_ack_b;
  logic signed [16:0] o_psum_b;
  logic               psum_rdy_b;
  logic               psum_zero_b;
  logic               busy_b;
  logic               ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_accum #(.IDWd(16), .ODWd(24), .CntWd(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_work(work),
    .i_acc_len(acc_len), .i_sum(i_sum),
    .sum_rdy(sum_rdy), .sum_ack(sum_ack),
    .sum_zero(sum_zero), .o_psum(o_psum),
    .psum_rdy(psum_rdy), .psum_ack(psum_ack),
    .psum_zero(psum_zero), .o_busy(busy), .o_ovf(ovf)
  );

  psum_accum #(.IDWd(16), .ODWd(17), .CntWd(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_work(work),
    .i_acc_len(acc_len), .i_sum(i_sum),
    .sum_rdy(sum_rdy), .sum_ack(sum_ack_b),
    .sum_zero(sum_zero), .o_psum(o_psum_b),
    .psum_rdy(psum_rdy_b), .psum_ack(psum_ack),
    .psum_zero(psum_zero_b), .o_busy(busy_b), .o_ovf(ovf_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic z, input int s);
    sum_rdy  = 1'b1;
    sum_zero = z;
    i_sum    = 16'(s);
    tick();
  endtask

  task automatic idle();
    sum_rdy  = 1'b0;
    sum_zero = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; work = 1'b1; sum_rdy = 1'b1;
    #1;
    checks++;
    if (sum_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack got %0d want 0", sum_ack);
    end
    tick(); tick();
    rst = 1'b0; work = 1'b0; sum_rdy = 1'b0;
    #1;
    checks++;
    if (o_psum !== 24'sd0 || psum_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got %0d/%0d want 0/0",
               o_psum, psum_rdy);
    end
    checks++;
    if (psum_zero !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got z%0d b%0d o%0d want 1 0 0",
               psum_zero, busy, ovf);
    end
    checks++;
    if (sum_ack !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack got %0d want 0", sum_ack);
    end
    tick();
  endtask

  task automatic test_basic();
    int vals[4] = '{10, -3, 7, 100};
    work = 1'b1; psum_ack = 1'b1; acc_len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      sum_rdy = 1'b1; sum_zero = 1'b0; i_sum = 16'(vals[i]);
      #1;
      checks++;
      if (sum_ack !== 1'b1 || psum_rdy !== 1'b0) begin
        errors++;
        $display("FAIL basic_ack%0d got %0d/%0d want 1/0",
                 i, sum_ack, psum_rdy);
      end
      tick();
    end
    sum_rdy = 1'b0;
    checks++;
    if (psum_rdy !== 1'b1 || o_psum !== 24'sd114) begin
      errors++;
      $display("FAIL basic_sum got %0d/%0d want 1/114",
               psum_rdy, o_psum);
    end
    checks++;
    if (psum_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got z%0d b%0d want 0 0",
               psum_zero, busy);
    end
    tick();
    checks++;
    if (psum_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop got %0d want 0", psum_rdy);
    end
  endtask

  task automatic test_zero();
    acc_len = 8'd3;
    beat(1'b1, 32'h7FFF);
    beat(1'b1, 32'h7FFF);
    beat(1'b1, 32'h7FFF);
    checks++;
    if (o_psum !== 24'sd0 || psum_zero !== 1'b1 || psum_rdy !== 1'b1) begin
      errors++;
      $display("FAIL zero_grp got %0d z%0d r%0d want 0 1 1",
               o_psum, psum_zero, psum_rdy);
    end
    beat(1'b1, 32'h1234);
    beat(1'b0, 5);
    beat(1'b1, 32'h7FFF);
    checks++;
    if (o_psum !== 24'sd5 || psum_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_mix got %0d z%0d want 5 0",
               o_psum, psum_zero);
    end
    idle();
  endtask

  task automatic test_backpressure();
    acc_len = 8'd2; psum_ack = 1'b1;
    beat(1'b0, 1);
    beat(1'b0, 2);
    psum_ack = 1'b0;
    sum_rdy = 1'b1; i_sum = 16'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (sum_ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_ack%0d got %0d want 0", i, sum_ack);
      end
      tick();
      checks++;
      if (o_psum !== 24'sd3 || psum_rdy !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got %0d r%0d b%0d want 3 1 0",
                 i, o_psum, psum_rdy, busy);
      end
    end
    psum_ack = 1'b1;
    #1;
    checks++;
    if (sum_ack !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %0d want 1", sum_ack);
    end
    tick();
    checks++;
    if (psum_rdy !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_mid got r%0d b%0d want 0 1",
               psum_rdy, busy);
    end
    beat(1'b0, 4);
    checks++;
    if (o_psum !== 24'sd7 || psum_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next got %0d r%0d want 7 1",
               o_psum, psum_rdy);
    end
    idle();
  endtask

  task automatic test_single();
    acc_len = 8'd1; psum_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sum_rdy = 1'b1; sum_zero = 1'b0; i_sum = 16'(k);
      #1;
      checks++;
      if (sum_ack !== 1'b1) begin
        errors++;
        $display("FAIL single_ack%0d got %0d want 1", k, sum_ack);
      end
      if (k > 1) begin
        checks++;
        if (psum_rdy !== 1'b1 || o_psum !== 24'(k - 1)) begin
          errors++;
          $display("FAIL single_out%0d got %0d r%0d want %0d 1",
                   k, o_psum, psum_rdy, k - 1);
        end
      end
      tick();
    end
    acc_len = 8'd0;
    beat(1'b0, -5);
    checks++;
    if (o_psum !== 24'sd8 && o_psum !== -24'sd5) begin
      errors++;
      $display("FAIL single_last got %0d", o_psum);
    end
    checks++;
    if (psum_rdy !== 1'b1 || o_psum !== -24'sd5) begin
      errors++;
      $display("FAIL len0 got %0d r%0d want -5 1",
               o_psum, psum_rdy);
    end
    idle();
    checks++;
    if (psum_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got %0d want 0", psum_rdy);
    end
  endtask

  task automatic test_len_change();
    acc_len = 8'd2;
    beat(1'b0, 20);
    acc_len = 8'd5;
    beat(1'b0, 22);
    checks++;
    if (psum_rdy !== 1'b1 || o_psum !== 24'sd42 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lenchg got %0d r%0d b%0d want 42 1 0",
               o_psum, psum_rdy, busy);
    end
    idle();
  endtask

  task automatic test_saturate();
    pulse_rst();
    acc_len = 8'd8; psum_ack = 1'b1;
    for (int i = 0; i < 8; i++) beat(1'b0, 32767);
    sum_rdy = 1'b0;
    checks++;
    if (o_psum_b !== 17'h0FFFF || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos got %0d o%0d want 65535 1",
               o_psum_b, ovf_b);
    end
    checks++;
    if (o_psum !== 24'sd262136 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL wide_pos got %0d o%0d want 262136 0",
               o_psum, ovf);
    end
    acc_len = 8'd1;
    beat(1'b0, 5);
    checks++;
    if (o_psum_b !== 17'sd5 || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %0d o%0d want 5 1",
               o_psum_b, ovf_b);
    end
    acc_len = 8'd8;
    for (int i = 0; i < 8; i++) beat(1'b0, -32768);
    sum_rdy = 1'b0;
    checks++;
    if (o_psum_b !== 17'h10000 || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg got %0d o%0d want -65536 1",
               o_psum_b, ovf_b);
    end
    checks++;
    if (o_psum !== -24'sd262144) begin
      errors++;
      $display("FAIL wide_neg got %0d want -262144", o_psum);
    end
    idle();
  endtask

  task automatic test_hold_reset();
    pulse_rst();
    acc_len = 8'd4; psum_ack = 1'b1;
    beat(1'b0, 10);
    beat(1'b0, 20);
    work = 1'b0;
    sum_rdy = 1'b1; i_sum = 16'd99;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (sum_ack !== 1'b0) begin
        errors++;
        $display("FAIL hold_ack%0d got %0d want 0", i, sum_ack);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || psum_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold_state%0d got b%0d r%0d want 1 0",
                 i, busy, psum_rdy);
      end
    end
    work = 1'b1;
    beat(1'b0, 30);
    beat(1'b0, 40);
    checks++;
    if (o_psum !== 24'sd100 || psum_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hold_sum got %0d r%0d want 100 1",
               o_psum, psum_rdy);
    end
    beat(1'b0, 1);
    beat(1'b0, 2);
    sum_rdy = 1'b1; i_sum = 16'd50;
    pulse_rst();
    sum_rdy = 1'b0;
    checks++;
    if (psum_rdy !== 1'b0 || busy !== 1'b0 || o_psum !== 24'sd0) begin
      errors++;
      $display("FAIL midrst got r%0d b%0d %0d want 0 0 0",
               psum_rdy, busy, o_psum);
    end
    for (int i = 0; i < 4; i++) beat(1'b0, 1);
    sum_rdy = 1'b0;
    checks++;
    if (o_psum !== 24'sd4 || psum_rdy !== 1'b1) begin
      errors++;
      $display("FAIL postrst got %0d r%0d want 4 1",
               o_psum, psum_rdy);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; work = 1'b0; acc_len = 8'd0; i_sum = 16'd0;
    sum_rdy = 1'b0; sum_zero = 1'b0; psum_ack = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_single();
    test_len_change();
    test_saturate();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Sits directly downstream of the arithmetic unit.
- Consumes its registered dot-product sums over the rdy/ack/zero pixel handshake and accumulates a programmable number of consecutive sums into one wide signed partial sum.
- Presents the partial sum to the next stage (output buffer / requantiser) over the same handshake style.
- Provides back-pressure, saturation and zero-group propagation, so zero-skipped groups can be dropped downstream.

Parameters:
- IDWd, 16, signed input sum width; matches the arithmetic unit output width.
- ODWd, 24, signed accumulated partial-sum width; must be greater than IDWd.
- CntWd, 8, width of the group-length field.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_work  in  1  global enable; when 0 all registers hold.
- i_acc_len  in  CntWd  sums per group; 0 is treated as 1; sampled on the first beat of each group.
- i_sum  in  IDWd  signed input sum.
- sum_rdy  in  1  input valid.
- sum_ack  out  1  input accepted this cycle.
- sum_zero  in  1  input sum is a skipped/zero result; i_sum is don't-care.
- o_psum  out  ODWd  signed partial sum.
- psum_rdy  out  1  output valid.
- psum_ack  in  1  downstream accepts the output.
- psum_zero  out  1  every beat of the emitted group had sum_zero=1.
- o_busy  out  1  group in progress (cnt!=0).
- o_ovf  out  1  sticky saturation flag.

Behaviour:

Reset (synchronous, i_rst=1, overrides i_work):
- Outputs: o_psum=0, psum_rdy=0, psum_zero=1, o_ovf=0, o_busy=0.
- Internal: acc=0, cnt=0, zacc=1, len_q=0.
- Reset mid-group discards the partial group and any pending output.

Hold (i_work=0):
- sum_ack=0.
- All registers hold, including psum_rdy and o_psum.
- psum_ack is ignored.

Input handshake:
- sum_ack = i_work && (!psum_rdy || psum_ack) && !i_rst. This is combinational.
- Beat: sum_rdy && sum_ack.
- No beat is lost or duplicated. sum_ack does not depend on sum_rdy.

Beat value:
- v = sum_zero ? 0 : sign_extend(i_sum) to ODWd.

Group counter:
- On a beat with cnt==0: len_q = max(i_acc_len, 1).
- last = (cnt + 1 == effective length), where effective length is len_q, or the just-sampled value on the first beat.

Non-last beat:
- acc = sat(acc + v).
- zacc = zacc & sum_zero.
- cnt++.

Last beat (same cycle):
- o_psum = sat(acc + v).
- psum_zero = zacc & sum_zero.
- psum_rdy = 1.
- acc = 0, zacc = 1, cnt = 0.
- Latency: the last input beat appears on o_psum/psum_rdy on the next edge.

Output handshake:
- psum_rdy && psum_ack with no simultaneous last beat: psum_rdy=0.
- With a simultaneous last beat: psum_rdy stays 1 and o_psum is replaced by the new group. This gives back-to-back groups at full rate.
- o_psum and psum_zero are stable while psum_rdy=1 && !psum_ack.

Back-pressure:
- While psum_rdy=1 && !psum_ack, sum_ack=0, including non-last beats.
- This keeps the design simple and predictable.

Saturation:
- sat() clamps to [-2^(ODWd-1), 2^(ODWd-1)-1].
- On clamp, o_ovf=1 (sticky until reset).
- The intermediate sum is computed in ODWd+1 bits.

Single-beat groups:
- i_acc_len of 0 or 1: every beat emits; psum = sign_extend(i_sum).

Length changes:
- A change to i_acc_len mid-group has no effect until the next group's first beat.

State summary:
- IDLE: cnt==0, no pending output.
- ACC: cnt!=0.
- FULL: psum_rdy=1.
- ACC and FULL are orthogonal flags. o_busy = (cnt!=0).

Test Plan:
- Reset then i_acc_len=4, i_work=1; feed sums 10, -3, 7, 100 with psum_ack=1 → one cycle after the 4th beat: o_psum=114, psum_rdy=1 for 1 cycle, psum_zero=0, sum_ack high on every cycle.
- i_acc_len=3; three beats with sum_zero=1 and i_sum=0x7FFF (garbage) → o_psum=0, psum_zero=1. Then a group of (zero, 5, zero) → o_psum=5, psum_zero=0.
- i_acc_len=2; groups (1,2) then (3,4); hold psum_ack=0 for 5 cycles after the first result → sum_ack=0 during the stall, o_psum held at 3. Release psum_ack → the next accepted group yields 7 with no beats lost.
- i_acc_len=1, continuous sum_rdy, psum_ack=1, sums 1..8 → 8 outputs on consecutive cycles with o_psum=1..8 and psum_rdy high continuously.
- ODWd=17 build, i_acc_len=8, eight beats of 32767 → o_psum=65535 (clamped), o_ovf=1, which stays 1 after subsequent normal groups. Repeat with -32768 → o_psum=-65536.
- Mid-group (cnt=2 of 4): drop i_work for 3 cycles → sum_ack=0 and state held; resume → correct 4-beat sum. Then assert i_rst at cnt=2 → next cycle psum_rdy=0, o_busy=0, o_psum=0, and the following group sums only post-reset beats.
